fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Pointer and flag controller for the 16-entry, 8-bit sample FIFO memory array in the audio effects datapath.
- Accepts write and read requests from producer and consumer stages (e.g. I2S receiver and effect pipeline).
- Generates the write enable and the 5-bit write/read pointers that drive the memory array.
- Reports full/empty, fill level and programmable almost-full/almost-empty thresholds.

Parameters:
- ADDR_W, 4, memory address width; depth = 2**ADDR_W = 16; pointers are ADDR_W+1 bits (MSB is the wrap bit)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- wr_req  in  1  producer requests a write of the current data_in this cycle
- rd_req  in  1  consumer requests to pop the current head entry this cycle
- err_clr  in  1  synchronous clear of the sticky error flags
- fifo_we  out  1  write enable to memory array
- wptr  out  ADDR_W+1  write pointer to memory array
- rptr  out  ADDR_W+1  read pointer to memory array
- rd_ack  out  1  read accepted; memory data_out is valid in this same cycle
- full  out  1  FIFO holds 2**ADDR_W entries
- empty  out  1  FIFO holds 0 entries
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_W+1  fill level, 0..16
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1): wptr=0, rptr=0, overflow=0, underflow=0. Derived outputs follow: empty=1, full=0, count=0, almost_empty=1, almost_full=0, fifo_we=0, rd_ack=0.
- The registered state is wptr, rptr, overflow and underflow. All other outputs are combinational from the registers and the current-cycle requests.
- fifo_we = wr_req & ~full. rd_ack = rd_req & ~empty.
- Pointer update: wptr <= wptr+1 when fifo_we. rptr <= rptr+1 when rd_ack. Both are modulo 2**(ADDR_W+1), so the wrap bit toggles every 16 entries.
- empty = (wptr == rptr).
- full = (wptr[ADDR_W] != rptr[ADDR_W]) & (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]).
- count = wptr - rptr, modulo 2**(ADDR_W+1), unsigned. It is never greater than 16.
- Read timing: the memory array read is combinational on rptr. When rd_ack=1, data_out is the head entry in that same cycle, and rptr advances at the next edge. Zero-latency pop.
- Write timing: data is written at the edge where fifo_we=1. empty deasserts and count increments in the following cycle. There is no same-cycle write-to-read bypass.
- Simultaneous wr_req & rd_req:
  - not full and not empty: both accepted, count unchanged, both pointers advance.
  - full: read accepted, write rejected; the FIFO is still full as of the start of the cycle.
  - empty: write accepted, read rejected.
- Wrap-around: after 16 writes from reset with no reads, wptr=5'b10000, rptr=0, full=1, count=16.
- Reset mid-operation: reset immediately discards all contents by returning the pointers to 0. The memory array contents are not cleared, and are not readable because empty=1.
- Rejected requests (write when full, read when empty) change no pointer state.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow <= 1 at any edge with wr_req & full.
  - underflow <= 1 at any edge with rd_req & empty.
  - Both flags hold until err_clr=1 at an edge or rst.
  - If err_clr and a new error event occur in the same cycle, the flag is set (error wins).
- Undefined: overflow and underflow are tied to 0, err_clr is ignored, and no flag registers are synthesized. Ports remain present in both builds.

Test Plan:
- Reset, then 16 writes with data 8'h00..8'h0F and no reads -> full=1, count=16, wptr=5'h10, almost_full asserted from the 12th write onward.
- From full, 16 reads -> rd_ack=1 each cycle, data_out sequence 8'h00..8'h0F, then empty=1, rptr=5'h10, count=0.
- Empty FIFO, wr_req=rd_req=1 for 1 cycle -> fifo_we=1, rd_ack=0; next cycle count=1, empty=0.
- Full FIFO, wr_req=rd_req=1 for 1 cycle -> fifo_we=0, rd_ack=1, count=15. With FIFO_ERR_FLAGS_EN, overflow=1 afterwards; one cycle of err_clr returns it to 0.
- Continuous simultaneous read/write for 40 cycles at count=8 -> count stays 8, pointers wrap past 5'h1F to 5'h00, data order preserved.
- Assert rst mid-stream at count=5 (asynchronously, not clock-aligned) -> empty=1, count=0, wptr=rptr=0 immediately; a subsequent read attempt gives rd_ack=0 and sets underflow=1 (when FIFO_ERR_FLAGS_EN is defined).

Source files
------------

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 2**ADDR_W-entry sample FIFO with wrap-bit pointers.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              err_clr,
    output logic              fifo_we,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr,
    output logic              rd_ack,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              PW      = ADDR_W + 1;
    localparam logic [PW-1:0]   AF_THR  = PW'(AF_LEVEL);
    localparam logic [PW-1:0]   AE_THR  = PW'(AE_LEVEL);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    logic [PW-1:0] wptr_q;
    logic [PW-1:0] wptr_d;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rptr_d;
    logic [PW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    logic          fifo_we_s;
    logic          rd_ack_s;

    // Occupancy status and request acceptance, all from the current pointers.
    always_comb begin
        count_s   = wptr_q - rptr_q;
        empty_s   = (wptr_q == rptr_q);
        full_s    = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                    (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
        fifo_we_s = wr_req & ~full_s;
        rd_ack_s  = rd_req & ~empty_s;
    end

    // Pointer advance; rejected requests leave the pointers untouched.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (fifo_we_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_ack_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= {PW{1'b0}};
            rptr_q <= {PW{1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Sticky error flags: a new error event takes priority over err_clr.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_req & full_s) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_req & empty_s) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign fifo_we      = fifo_we_s;
    assign rd_ack       = rd_ack_s;
    assign wptr         = wptr_q;
    assign rptr         = rptr_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_s;
    assign almost_full  = (count_s >= AF_THR);
    assign almost_empty = (count_s <= AE_THR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed scoreboard bench for fifo_ctrl; models the 16x8 memory array around the controller.
module tb_fifo_ctrl;

    localparam int AW = 4;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic          rd_req;
    logic          err_clr;
    logic          fifo_we;
    logic          rd_ack;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    fifo_ctrl #(.ADDR_W(AW), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .fifo_we      (fifo_we),
        .wptr         (wptr),
        .rptr         (rptr),
        .rd_ack       (rd_ack),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    logic [7:0] mem [16];
    logic [7:0] sb [$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         m_cnt;
    logic [4:0] m_wp;
    logic [4:0] m_rp;
    logic       m_ovf;
    logic       m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".wptr"}, 32'(wptr), 32'(m_wp));
        chk({tag, ".rptr"}, 32'(rptr), 32'(m_rp));
        chk({tag, ".empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == 16));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(m_cnt >= 12));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_cnt <= 2));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf & FLAGS));
        chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf & FLAGS));
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_wp  = 5'd0;
        m_rp  = 5'd0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        sb.delete();
    endtask

    // One clock cycle of requests: checks state and acceptance, then applies the edge.
    task automatic cyc(input logic w, input logic r, input logic ec, input logic [7:0] d);
        bit         aw;
        bit         ar;
        logic [7:0] exp_d;
        logic [3:0] wa;
        logic       we_seen;
        @(negedge clk);
        wr_req  = w;
        rd_req  = r;
        err_clr = ec;
        #1;
        aw = w && (m_cnt != 16);
        ar = r && (m_cnt != 0);
        chk_state("cyc");
        chk("fifo_we", 32'(fifo_we), 32'(aw));
        chk("rd_ack", 32'(rd_ack), 32'(ar));
        if (ar && sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk("data_out", 32'(mem[rptr[3:0]]), 32'(exp_d));
        end
        wa      = wptr[3:0];
        we_seen = fifo_we;
        @(posedge clk);
        if (we_seen) mem[wa] = d;
        if (w && m_cnt == 16) m_ovf = 1'b1;
        else if (ec) m_ovf = 1'b0;
        if (r && m_cnt == 0) m_udf = 1'b1;
        else if (ec) m_udf = 1'b0;
        if (aw) begin
            sb.push_back(d);
            m_wp = m_wp + 5'd1;
            m_cnt++;
        end
        if (ar) begin
            m_rp = m_rp + 5'd1;
            m_cnt--;
        end
    endtask

    initial begin
        rst     = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        err_clr = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        #12;
        chk_state("reset");
        chk("reset.fifo_we", 32'(fifo_we), 32'd0);
        chk("reset.rd_ack", 32'(rd_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill from empty with 00..0F.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        #1;
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.wptr", 32'(wptr), 32'h10);

        // Drain all sixteen, data order 00..0F.
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.rptr", 32'(rptr), 32'h10);
        chk("drain.count", 32'(count), 32'd0);

        // Simultaneous request while empty: write only, underflow event.
        cyc(1'b1, 1'b1, 1'b0, 8'hA0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);

        // Refill, then simultaneous request while full: read only, overflow event.
        for (int i = 1; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 1'b1, 8'h5A);
        cyc(1'b1, 1'b0, 1'b1, 8'h5B);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain to eight, then 40 cycles of streaming with wrap.
        while (m_cnt > 8) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        // Drain to five and reset asynchronously mid-cycle.
        while (m_cnt > 5) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        chk("arst.wptr", 32'(wptr), 32'd0);
        chk("arst.rptr", 32'(rptr), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
